// File: rtl/gtp_frame_tx.sv
// rtl/gtp_frame_tx.sv - store-and-forward framer: header, buffered payload, XOR trailer to the GTP TX FIFO
module gtp_frame_tx #(
    parameter int MAX_LEN = 16
) (
    input  logic        core_clk,
    input  logic        reset_n,
    input  logic [31:0] src_tdata,
    input  logic        src_tvalid,
    output logic        src_tready,
    input  logic        src_tlast,
    input  logic [7:0]  frame_type,
    input  logic        channel_up,
    output logic [31:0] core2gtp_tdata,
    output logic        core2gtp_tvalid,
    input  logic        core2gtp_tready,
    output logic        core2gtp_tlast,
    output logic [15:0] frames_sent,
    output logic        trunc_err,
    output logic        busy
);

    localparam int         AW       = $clog2(MAX_LEN);
    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    typedef enum logic [2:0] {FILL, DRAIN, WAIT_LINK, HDR, DATA, TRL} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_buf [MAX_LEN];
    logic [7:0]  r_cnt;
    logic [7:0]  r_rd;
    logic [31:0] r_acc;
    logic [7:0]  r_seq;
    logic [7:0]  r_type;
    logic [15:0] r_frames;
    logic        r_trunc;
    logic        r_started;
    logic        w_src_hs;
    logic        w_out_hs;
    logic        w_fill_full;
    logic [31:0] w_header;

    assign w_src_hs    = src_tvalid & src_tready;
    assign w_out_hs    = core2gtp_tvalid & core2gtp_tready;
    assign w_fill_full = (r_cnt == LAST_IDX) & ~src_tlast;
    // r_cnt equals the frame length once the frame-ending beat has been stored
    assign w_header    = {8'hA5, r_seq, r_type, r_cnt};
    assign frames_sent = r_frames;
    assign trunc_err   = r_trunc;

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) r_state <= FILL;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL: begin
                if (w_src_hs && w_fill_full)
                    w_next = DRAIN;
                else if (w_src_hs && src_tlast)
                    w_next = channel_up ? HDR : WAIT_LINK;
            end
            DRAIN:     if (w_src_hs && src_tlast) w_next = channel_up ? HDR : WAIT_LINK;
            WAIT_LINK: if (channel_up) w_next = HDR;
            HDR:       if (w_out_hs) w_next = DATA;
            DATA:      if (w_out_hs && (r_rd == r_cnt - 8'd1)) w_next = TRL;
            TRL:       if (w_out_hs) w_next = FILL;
            default:   w_next = FILL;
        endcase
    end

    always_comb begin
        src_tready      = 1'b0;
        core2gtp_tvalid = 1'b0;
        core2gtp_tlast  = 1'b0;
        core2gtp_tdata  = '0;
        busy            = 1'b1;
        case (r_state)
            FILL: begin
                src_tready = r_started;
                busy       = 1'b0;
            end
            DRAIN: src_tready = r_started;
            HDR: begin
                core2gtp_tvalid = 1'b1;
                core2gtp_tdata  = w_header;
            end
            DATA: begin
                core2gtp_tvalid = 1'b1;
                core2gtp_tdata  = r_buf[r_rd[AW-1:0]];
            end
            TRL: begin
                core2gtp_tvalid = 1'b1;
                core2gtp_tlast  = 1'b1;
                core2gtp_tdata  = r_acc ^ w_header;
            end
            default: ;
        endcase
    end

    // Payload storage carries no reset so it can map onto RAM
    always_ff @(posedge core_clk) begin
        if (r_state == FILL && w_src_hs)
            r_buf[r_cnt[AW-1:0]] <= src_tdata;
    end

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_rd      <= '0;
            r_acc     <= '0;
            r_seq     <= '0;
            r_type    <= '0;
            r_frames  <= '0;
            r_trunc   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                FILL: begin
                    if (w_src_hs) begin
                        r_cnt <= r_cnt + 8'd1;
                        r_acc <= r_acc ^ src_tdata;
                        if (r_cnt == 8'd0) r_type <= frame_type;
                        if (w_fill_full) r_trunc <= 1'b1;
                    end
                end
                HDR:  if (w_out_hs) r_rd <= '0;
                DATA: if (w_out_hs) r_rd <= r_rd + 8'd1;
                TRL: begin
                    if (w_out_hs) begin
                        r_seq    <= r_seq + 8'd1;
                        r_frames <= r_frames + 16'd1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gtp_frame_tx.sv
// tb/tb_gtp_frame_tx.sv - directed scoreboard bench for gtp_frame_tx
module tb_gtp_frame_tx;

    localparam int MAX_LEN = 16;

    logic        core_clk = 1'b0;
    logic        reset_n;
    logic [31:0] src_tdata;
    logic        src_tvalid;
    logic        src_tready;
    logic        src_tlast;
    logic [7:0]  frame_type;
    logic        channel_up;
    logic [31:0] core2gtp_tdata;
    logic        core2gtp_tvalid;
    logic        core2gtp_tready;
    logic        core2gtp_tlast;
    logic [15:0] frames_sent;
    logic        trunc_err;
    logic        busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q [$];
    logic [7:0]  m_seq    = 8'd0;
    int          m_frames = 0;
    logic        stall_prev = 1'b0;
    logic [32:0] held_beat;

    gtp_frame_tx #(.MAX_LEN(MAX_LEN)) dut (
        .core_clk        (core_clk),
        .reset_n         (reset_n),
        .src_tdata       (src_tdata),
        .src_tvalid      (src_tvalid),
        .src_tready      (src_tready),
        .src_tlast       (src_tlast),
        .frame_type      (frame_type),
        .channel_up      (channel_up),
        .core2gtp_tdata  (core2gtp_tdata),
        .core2gtp_tvalid (core2gtp_tvalid),
        .core2gtp_tready (core2gtp_tready),
        .core2gtp_tlast  (core2gtp_tlast),
        .frames_sent     (frames_sent),
        .trunc_err       (trunc_err),
        .busy            (busy)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] ftype, input int n, input logic [31:0] base);
        logic [31:0] hdr;
        logic [31:0] acc;
        int          len;
        len = (n > MAX_LEN) ? MAX_LEN : n;
        hdr = {8'hA5, m_seq, ftype, 8'(len)};
        acc = 32'd0;
        exp_q.push_back({1'b0, hdr});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b0, base + 32'(i)});
            acc = acc ^ (base + 32'(i));
        end
        exp_q.push_back({1'b1, acc ^ hdr});
        m_seq = m_seq + 8'd1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        src_tdata  = d;
        src_tlast  = last;
        src_tvalid = 1'b1;
        @(negedge core_clk);
        while (!src_tready && t < 200) begin
            @(negedge core_clk);
            t++;
        end
        check("src_accept_timeout", 33'(t >= 200), 33'd0);
        @(posedge core_clk);
        #1;
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ftype, input int n, input logic [31:0] base);
        frame_type = ftype;
        for (int i = 0; i < n; i++)
            push_beat(base + 32'(i), i == n - 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge core_clk);
            t++;
        end
        check("drain_timeout", 33'(exp_q.size()), 33'd0);
        @(posedge core_clk);
        #1;
    endtask

    always @(negedge core_clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && core2gtp_tvalid)
                check("hold_stable", {core2gtp_tlast, core2gtp_tdata}, held_beat);
            if (core2gtp_tvalid && core2gtp_tready) begin
                check("beat_expected", 33'(exp_q.size() != 0), 33'd1);
                if (exp_q.size() != 0)
                    check("out_beat", {core2gtp_tlast, core2gtp_tdata}, exp_q.pop_front());
            end
            stall_prev = core2gtp_tvalid && !core2gtp_tready;
            held_beat  = {core2gtp_tlast, core2gtp_tdata};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        src_tdata       = '0;
        src_tvalid      = 1'b0;
        src_tlast       = 1'b0;
        frame_type      = '0;
        channel_up      = 1'b1;
        core2gtp_tready = 1'b1;

        @(posedge core_clk);
        #1;
        check("rst_src_tready", src_tready, 0);
        check("rst_tvalid", core2gtp_tvalid, 0);
        check("rst_tlast", core2gtp_tlast, 0);
        check("rst_tdata", core2gtp_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_trunc", trunc_err, 0);
        @(posedge core_clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("tready_before_edge", src_tready, 0);
        @(posedge core_clk);
        #1;
        check("tready_after_edge", src_tready, 1);

        // basic three-word frame, checksum cancels to the header
        expect_frame(8'h11, 3, 32'h1);
        send_frame(8'h11, 3, 32'h1);
        check("latency_tvalid", core2gtp_tvalid, 1);
        check("hdr_word", core2gtp_tdata, 32'hA5001103);
        check("busy_in_hdr", busy, 1);
        check("src_tready_in_hdr", src_tready, 0);
        wait_idle();
        m_frames++;
        check("frames_after_first", frames_sent, 16'(m_frames));

        // 20-word frame truncated to MAX_LEN
        expect_frame(8'h22, 20, 32'h1000);
        send_frame(8'h22, 20, 32'h1000);
        check("trunc_set", trunc_err, 1);
        wait_idle();
        m_frames++;
        check("frames_after_trunc", frames_sent, 16'(m_frames));

        // link down at frame end, then link drop during transmission
        channel_up = 1'b0;
        expect_frame(8'h77, 2, 32'hBEEF0000);
        send_frame(8'h77, 2, 32'hBEEF0000);
        repeat (10) begin
            @(negedge core_clk);
            check("wait_tvalid", core2gtp_tvalid, 0);
            check("wait_busy", busy, 1);
            check("wait_src_tready", src_tready, 0);
        end
        @(posedge core_clk);
        #1;
        channel_up = 1'b1;
        @(negedge core_clk);
        check("wait_same_cycle", core2gtp_tvalid, 0);
        @(posedge core_clk);
        #1;
        check("hdr_after_link", core2gtp_tvalid, 1);
        channel_up = 1'b0;
        wait_idle();
        channel_up = 1'b1;
        m_frames++;
        check("frames_after_link", frames_sent, 16'(m_frames));
        check("trunc_sticky", trunc_err, 1);

        // backpressure pattern 1,0,0,1 during DATA
        core2gtp_tready = 1'b0;
        expect_frame(8'h66, 4, 32'hC0DE0000);
        send_frame(8'h66, 4, 32'hC0DE0000);
        core2gtp_tready = 1'b1;
        @(posedge core_clk);
        #1;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pat;
            pat = 4'b1001;
            core2gtp_tready = pat[i];
            @(posedge core_clk);
            #1;
        end
        core2gtp_tready = 1'b1;
        wait_idle();
        m_frames++;
        check("frames_after_stall", frames_sent, 16'(m_frames));

        // asynchronous reset while in DATA
        core2gtp_tready = 1'b0;
        expect_frame(8'h33, 5, 32'h100);
        send_frame(8'h33, 5, 32'h100);
        core2gtp_tready = 1'b1;
        @(posedge core_clk);
        #1;
        core2gtp_tready = 1'b0;
        check("in_data_tvalid", core2gtp_tvalid, 1);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_tvalid", core2gtp_tvalid, 0);
        check("async_tdata", core2gtp_tdata, 0);
        check("async_busy", busy, 0);
        check("async_frames", frames_sent, 0);
        check("async_trunc", trunc_err, 0);
        @(posedge core_clk);
        #1;
        reset_n         = 1'b1;
        core2gtp_tready = 1'b1;
        m_seq           = 8'd0;
        m_frames        = 0;
        expect_frame(8'h44, 1, 32'h5555AAAA);
        send_frame(8'h44, 1, 32'h5555AAAA);
        check("post_rst_seq", core2gtp_tdata[23:16], 8'h00);
        check("post_rst_frames_pending", frames_sent, 0);
        wait_idle();
        m_frames++;
        check("post_rst_frames", frames_sent, 16'(m_frames));

        // 256 single-word frames from a clean reset, sequence wraps on the 257th
        reset_n = 1'b0;
        @(posedge core_clk);
        #1;
        reset_n  = 1'b1;
        m_seq    = 8'd0;
        m_frames = 0;
        for (int f = 0; f < 256; f++) begin
            expect_frame(8'h5A, 1, 32'(f));
            send_frame(8'h5A, 1, 32'(f));
            m_frames++;
        end
        wait_idle();
        check("frames_256", frames_sent, 16'(m_frames));
        expect_frame(8'h5A, 1, 32'hFFFF0000);
        send_frame(8'h5A, 1, 32'hFFFF0000);
        check("wrap_seq", core2gtp_tdata[23:16], 8'h00);
        wait_idle();
        m_frames++;
        check("frames_257", frames_sent, 16'(m_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gtp_frame_tx.md
GTP_FRAME_TX -- requirements
Module: gtp_frame_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16; maximum payload words per frame; legal range 2..128.
REQ-002 SHALL have port core_clk, input, 1; the single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1; asynchronous, active-low reset.
REQ-004 SHALL have port src_tdata, input, 32; payload word from the core.
REQ-005 SHALL have port src_tvalid, input, 1; payload beat valid.
REQ-006 SHALL have port src_tready, output, 1; payload beat accepted when src_tvalid and src_tready are both 1.
REQ-007 SHALL have port src_tlast, input, 1; last payload word of the source frame.
REQ-008 SHALL have port frame_type, input, 8; frame type, sampled on the first accepted beat.
REQ-009 SHALL have port channel_up, input, 1; Aurora link status, already synchronous to core_clk.
REQ-010 SHALL have ports core2gtp_tdata (output, 32), core2gtp_tvalid (output, 1), core2gtp_tready (input, 1) and core2gtp_tlast (output, 1); the AXI-Stream master to the GTP TX FIFO.
REQ-011 SHALL have port frames_sent, output, 16; count of completed frames.
REQ-012 SHALL have port trunc_err, output, 1; sticky flag, set when a source frame exceeds MAX_LEN.
REQ-013 SHALL have port busy, output, 1; high in every state except FILL.

Function
REQ-014 SHALL implement the states FILL, DRAIN, WAIT_LINK, HDR, DATA and TRL.
REQ-015 SHALL store each frame in a MAX_LEN x 32 internal buffer and forward it (store-and-forward), keeping a word count cnt and a running 32-bit XOR acc.
REQ-016 In FILL, SHALL drive src_tready=1; on each accepted beat: buf[cnt]<=src_tdata, cnt++, acc^=src_tdata; on the first beat (cnt==0) SHALL latch frame_type.
REQ-017 A beat accepted in FILL with src_tlast=1 SHALL end the frame with len=cnt+1.
REQ-018 A beat accepted in FILL with src_tlast=0 and cnt==MAX_LEN-1 SHALL end the frame with len=MAX_LEN, set trunc_err, and go to DRAIN.
REQ-019 In DRAIN, SHALL drive src_tready=1 and discard beats without touching the buffer or acc; the accepted beat with src_tlast=1 SHALL move to HDR if channel_up=1, else to WAIT_LINK.
REQ-020 At the end of a frame in FILL, the next state SHALL be HDR if channel_up=1, else WAIT_LINK.
REQ-021 In WAIT_LINK, SHALL drive core2gtp_tvalid=0 and move to HDR in the cycle channel_up=1.
REQ-022 In HDR, SHALL drive core2gtp_tdata={8'hA5, seq[7:0], type[7:0], len[7:0]} with tlast=0; the handshake SHALL move to DATA with rd=0.
REQ-023 In DATA, SHALL drive core2gtp_tdata=buf[rd] with tlast=0; each handshake SHALL increment rd; the handshake at rd==len-1 SHALL move to TRL.
REQ-024 In TRL, SHALL drive core2gtp_tdata=acc^header with tlast=1; the handshake SHALL increment seq (wrapping 255->0) and frames_sent (wrapping 65535->0), clear cnt and acc, and go to FILL.
REQ-025 core2gtp_tvalid SHALL be 1 exactly in HDR, DATA and TRL.
REQ-026 While core2gtp_tvalid=1 and core2gtp_tready=0, core2gtp_tdata and core2gtp_tlast SHALL hold stable.
REQ-027 There SHALL be no combinational path from core2gtp_tready to core2gtp_tvalid or core2gtp_tdata.
REQ-028 src_tready SHALL be 0 in WAIT_LINK, HDR, DATA and TRL.
REQ-029 Once a frame has reached HDR, a drop of channel_up SHALL NOT abort it; the frame completes and is handled by the downstream FIFO.
REQ-030 Latency: core2gtp_tvalid SHALL rise in the cycle after the frame-ending beat when channel_up=1.
REQ-031 Throughput: a frame of len words SHALL occupy len+2 output beats.

Reset
REQ-032 reset_n=0 SHALL asynchronously force: state=FILL, cnt=rd=acc=seq=0, frames_sent=0, trunc_err=0, core2gtp_tvalid=0, core2gtp_tlast=0, core2gtp_tdata=0, busy=0, src_tready=0.
REQ-033 src_tready SHALL become 1 starting the first core_clk edge after reset_n deasserts.
REQ-034 A reset in the middle of a frame SHALL discard the partial frame; trunc_err SHALL clear only on reset.

Verification
REQ-035 Scenario: type=8'h11; payload 0x1,0x2,0x3 with tlast on 0x3; channel_up=1; tready=1 -> output A5001103, 1, 2, 3, then A5001103^0^... = 0xA5001103 (tlast=1); frames_sent=1.
REQ-036 Scenario: a 20-word frame with MAX_LEN=16 -> len field 0x10, 16 payload beats, trunc_err=1, words 17..20 dropped; the next frame has seq=1.
REQ-037 Scenario: channel_up=0 at frame end, held 10 cycles -> tvalid=0 and busy=1 through WAIT_LINK; header appears the cycle after channel_up rises.
REQ-038 Scenario: tready toggled 1,0,0,1 in DATA -> tdata held constant across the stalls; no beat skipped or duplicated.
REQ-039 Scenario: 256 one-word frames -> seq wraps to 0x00 in header 257; frames_sent=256.
REQ-040 Scenario: reset_n pulsed during DATA -> tvalid drops immediately without a clock edge; the next frame sent has seq=0 and frames_sent=0 before it completes.
